// File: rtl/ram_pkg.sv
// Shared definitions for the handshake RAM: init FSM states and the boot image
// written into the array after the zero-fill.
package ram_pkg;

    localparam int LESELATENZ_MAX = 4;
    localparam int BOOT_LAENGE    = 3;

    localparam logic [31:0] BOOT_PROGRAMM [BOOT_LAENGE] = '{
        32'h8020FFFF,
        32'hE8200000,
        32'h43FFFFFF
    };

    typedef enum logic [1:0] {
        INIT,
        BOOT,
        BETRIEB
    } ram_state_e;

    // Boot word k, or zero past the end of the program.
    function automatic logic [31:0] boot_wort(input logic [1:0] k);
        if (int'(k) < BOOT_LAENGE) begin
            return BOOT_PROGRAMM[k];
        end
        return '0;
    endfunction

endpackage

// File: rtl/ram_kern.sv
// Byte-masked synchronous memory array: one write port and one registered read.
// The array itself has no reset; only the read register does.
module ram_kern #(
    parameter int WORDSIZE = 32,
    parameter int WORDS    = 256
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       we_i,
    input  logic [WORDSIZE/8-1:0]      be_i,
    input  logic                       re_i,
    input  logic [$clog2(WORDS)-1:0]   addr_i,
    input  logic [WORDSIZE-1:0]        wdata_i,
    output logic [WORDSIZE-1:0]        rdata_o
);

    localparam int NB = WORDSIZE / 8;

    logic [WORDSIZE-1:0] mem_q [WORDS];
    logic [WORDSIZE-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < NB; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_mit_handshake.sv
// Single-port RAM with valid/ready requests, byte masks and a configurable read latency.
// After reset the FSM zero-fills the array and loads the boot program before accepting requests.
module ram_mit_handshake
    import ram_pkg::*;
#(
    parameter int WORDSIZE   = 32,
    parameter int WORDS      = 256,
    parameter int LESELATENZ = 1
) (
    input  logic                       Clock,
    input  logic                       Reset_n,
    input  logic                       Anfrage,
    output logic                       Bereit,
    input  logic                       SchreibenAn,
    input  logic [WORDSIZE/8-1:0]      ByteMaske,
    input  logic [$clog2(WORDS)-1:0]   Adresse,
    input  logic [WORDSIZE-1:0]        DatenRein,
    output logic [WORDSIZE-1:0]        DatenRaus,
    output logic                       DatenGueltig,
    output logic                       Fehler,
    output ram_state_e                 Zustand
);

    localparam int                ADDR_W    = $clog2(WORDS);
    localparam int                NB        = WORDSIZE / 8;
    localparam logic [ADDR_W:0]   WORDS_L   = (ADDR_W+1)'(WORDS);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS - 1);
    localparam logic [ADDR_W-1:0] LAST_BOOT = ADDR_W'(BOOT_LAENGE - 1);

    ram_state_e          state_q;
    logic [ADDR_W-1:0]   zaehler_q;
    logic                bereit_q;

    logic                annahme;
    logic                im_bereich;
    logic                kern_we;
    logic                kern_re;
    logic [NB-1:0]       kern_be;
    logic [ADDR_W-1:0]   kern_addr;
    logic [WORDSIZE-1:0] kern_wdata;
    logic [WORDSIZE-1:0] kern_rdata;

    logic                gueltig0_q;
    logic                fehler0_q;
    logic [WORDSIZE-1:0] daten0;

    // Valid/ready: a request is taken on an edge where Anfrage and Bereit are both high;
    // Bereit is registered and high only in BETRIEB, so nothing is accepted or queued during init.
    assign annahme    = Anfrage & bereit_q;
    assign im_bereich = ({1'b0, Adresse} < WORDS_L);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= INIT;
            zaehler_q <= '0;
            bereit_q  <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    if (zaehler_q == LAST_WORD) begin
                        state_q   <= BOOT;
                        zaehler_q <= '0;
                    end else begin
                        zaehler_q <= zaehler_q + ADDR_W'(1);
                    end
                end
                BOOT: begin
                    if (zaehler_q == LAST_BOOT) begin
                        state_q   <= BETRIEB;
                        bereit_q  <= 1'b1;
                        zaehler_q <= '0;
                    end else begin
                        zaehler_q <= zaehler_q + ADDR_W'(1);
                    end
                end
                BETRIEB: begin
                    bereit_q <= 1'b1;
                end
                default: begin
                    state_q   <= INIT;
                    zaehler_q <= '0;
                    bereit_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        kern_we    = 1'b0;
        kern_re    = 1'b0;
        kern_be    = '1;
        kern_addr  = zaehler_q;
        kern_wdata = '0;
        case (state_q)
            INIT: begin
                kern_we = 1'b1;
            end
            BOOT: begin
                kern_we    = 1'b1;
                kern_wdata = WORDSIZE'(boot_wort(zaehler_q[1:0]));
            end
            BETRIEB: begin
                kern_we    = annahme & SchreibenAn & im_bereich;
                kern_re    = annahme & ~SchreibenAn & im_bereich;
                kern_be    = ByteMaske;
                kern_addr  = Adresse;
                kern_wdata = DatenRein;
            end
            default: begin
                kern_we = 1'b0;
            end
        endcase
    end

    ram_kern #(
        .WORDSIZE (WORDSIZE),
        .WORDS    (WORDS)
    ) u_kern (
        .clk_i   (Clock),
        .rst_ni  (Reset_n),
        .we_i    (kern_we),
        .be_i    (kern_be),
        .re_i    (kern_re),
        .addr_i  (kern_addr),
        .wdata_i (kern_wdata),
        .rdata_o (kern_rdata)
    );

    // First response stage sits alongside the array's read register; an out-of-range
    // access flags Fehler and forces the data to zero.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            gueltig0_q <= 1'b0;
            fehler0_q  <= 1'b0;
        end else begin
            gueltig0_q <= annahme & ~SchreibenAn;
            fehler0_q  <= annahme & ~im_bereich;
        end
    end

    assign daten0 = fehler0_q ? '0 : kern_rdata;

    generate
        if (LESELATENZ <= 1) begin : g_direkt
            assign DatenRaus    = daten0;
            assign DatenGueltig = gueltig0_q;
            assign Fehler       = fehler0_q;
        end else begin : g_pipe
            localparam int N = LESELATENZ - 1;

            logic [WORDSIZE-1:0] daten_q   [N];
            logic                gueltig_q [N];
            logic                fehler_q  [N];

            always_ff @(posedge Clock or negedge Reset_n) begin
                if (!Reset_n) begin
                    for (int i = 0; i < N; i++) begin
                        daten_q[i]   <= '0;
                        gueltig_q[i] <= 1'b0;
                        fehler_q[i]  <= 1'b0;
                    end
                end else begin
                    daten_q[0]   <= daten0;
                    gueltig_q[0] <= gueltig0_q;
                    fehler_q[0]  <= fehler0_q;
                    for (int i = 1; i < N; i++) begin
                        daten_q[i]   <= daten_q[i-1];
                        gueltig_q[i] <= gueltig_q[i-1];
                        fehler_q[i]  <= fehler_q[i-1];
                    end
                end
            end

            assign DatenRaus    = daten_q[N-1];
            assign DatenGueltig = gueltig_q[N-1];
            assign Fehler       = fehler_q[N-1];
        end
    endgenerate

    assign Bereit  = bereit_q;
    assign Zustand = state_q;

endmodule
